// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the 1-to-N packet stream demultiplexer.
package stream_demux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_e;

  // Select width for a given channel count; never narrower than one bit.
  function automatic int sel_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry valid/ready holding register for a single demux output channel.
module demux_out_slot #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic         valid_r;
  logic [W-1:0] data_r;

  // Load has priority over drain so load+drain in one cycle keeps full rate.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= load_data;
    end else if (valid_r && out_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign out_valid = valid_r;
  assign out_data  = data_r;

endmodule

// File: rtl/stream_demux_1_n.sv
// Packet demultiplexer: routes each packet to the channel named on its first
// beat, discards packets addressed beyond N_CH and counts them.
module stream_demux_1_n
  import stream_demux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_data,
  input  logic [sel_w(N_CH)-1:0]   in_sel,
  input  logic                     in_last,
  output logic [N_CH-1:0]          out_valid,
  input  logic [N_CH-1:0]          out_ready,
  output logic [N_CH*DW-1:0]       out_data,
  output logic [N_CH-1:0]          out_last,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int SEL_W = sel_w(N_CH);
  localparam int PAD_W = 2 ** SEL_W;
  localparam logic [SEL_W:0] N_CH_L = (SEL_W + 1)'(N_CH);

  state_e             state_r;
  logic [SEL_W-1:0]   tgt_r;
  logic [CNT_W-1:0]   drop_cnt_r;

  logic [SEL_W-1:0]   chan_s;
  logic               sel_ok_s;
  logic [PAD_W-1:0]   free_pad_s;
  logic               accept_s;
  logic               fwd_s;
  logic [N_CH-1:0]    load_s;

  // Readiness depends only on registered slot state, out_ready and in_sel.
  always_comb begin
    chan_s     = (state_r == FWD) ? tgt_r : in_sel;
    sel_ok_s   = ({1'b0, in_sel} < N_CH_L);
    free_pad_s = PAD_W'(~out_valid | out_ready);
    if (rst) begin
      in_ready = 1'b0;
    end else begin
      case (state_r)
        IDLE:    in_ready = sel_ok_s ? free_pad_s[chan_s] : 1'b1;
        FWD:     in_ready = free_pad_s[chan_s];
        DROP:    in_ready = 1'b1;
        default: in_ready = 1'b0;
      endcase
    end
    accept_s = in_valid && in_ready;
    fwd_s    = accept_s && ((state_r == FWD) || ((state_r == IDLE) && sel_ok_s));
    for (int k = 0; k < N_CH; k++) begin
      load_s[k] = fwd_s && (chan_s == SEL_W'(k));
    end
  end

  // Packet-level state, locked target and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      tgt_r      <= '0;
      drop_cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && sel_ok_s) begin
            tgt_r   <= in_sel;
            state_r <= in_last ? IDLE : FWD;
          end else if (accept_s) begin
            state_r <= in_last ? IDLE : DROP;
            if (drop_cnt_r != {CNT_W{1'b1}}) begin
              drop_cnt_r <= drop_cnt_r + CNT_W'(1);
            end else begin
              drop_cnt_r <= drop_cnt_r;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        FWD, DROP: begin
          if (accept_s && in_last) begin
            state_r <= IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign drop_cnt = drop_cnt_r;

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    logic [DW:0] slot_data_s;

    demux_out_slot #(.W(DW + 1)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load_s[k]),
      .load_data ({in_last, in_data}),
      .out_ready (out_ready[k]),
      .out_valid (out_valid[k]),
      .out_data  (slot_data_s)
    );

    assign out_data[k*DW +: DW] = slot_data_s[DW-1:0];
    assign out_last[k]          = slot_data_s[DW];
  end

endmodule

// File: tb/tb_stream_demux_1_n.sv
// Self-checking bench: a 4-channel and a 3-channel (CNT_W=2) demux run against
// a packet-level reference model, plus directed scenarios with literal results.
module tb_stream_demux_1_n;

  typedef struct {int ch; int data; int last; int cyc;} beat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] iv, il, ir;
  logic [7:0] idat [2];
  logic [1:0] isel [2];
  logic [3:0] ordy [2];

  logic [3:0]  ova, ola;
  logic [31:0] oda;
  logic [15:0] dca;
  logic [2:0]  ovb, olb;
  logic [23:0] odb;
  logic [1:0]  dcb;

  int checks = 0, errors = 0, cyc = 0;
  bit chk_en = 1'b0, rand_rdy = 1'b0;
  int stall_from = -100, stall_seen = 0, b_valid_seen = 0, b_notready = 0;
  beat_t drained[$];

  // reference model: per-channel slots, packet progress, drop count
  bit         mv [2][4];
  logic [7:0] mdat [2][4];
  bit         ml [2][4];
  int         mcnt [2];
  bit         mpkt [2];
  int         mdest [2];

  stream_demux_1_n #(.N_CH(4), .DW(8), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idat[0]),
    .in_sel(isel[0]), .in_last(il[0]), .out_valid(ova), .out_ready(ordy[0]),
    .out_data(oda), .out_last(ola), .drop_cnt(dca));

  stream_demux_1_n #(.N_CH(3), .DW(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idat[1]),
    .in_sel(isel[1]), .in_last(il[1]), .out_valid(ovb), .out_ready(ordy[1][2:0]),
    .out_data(odb), .out_last(olb), .drop_cnt(dcb));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic dut_v(int u, int k);
    return (u == 0) ? ova[k] : ovb[k];
  endfunction
  function automatic logic dut_l(int u, int k);
    return (u == 0) ? ola[k] : olb[k];
  endfunction
  function automatic logic [7:0] dut_d(int u, int k);
    return (u == 0) ? oda[k*8 +: 8] : odb[k*8 +: 8];
  endfunction

  // Compare against the model, record drained beats, then advance the model.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      int n, d, cmax;
      bit er;
      n    = (u == 0) ? 4 : 3;
      cmax = (u == 0) ? 65535 : 3;
      if (mpkt[u]) d = mdest[u];
      else d = (int'(isel[u]) < n) ? int'(isel[u]) : -1;
      er = rst ? 1'b0 : ((d < 0) ? 1'b1 : (!mv[u][d] || ordy[u][d]));
      if (chk_en) begin
        chk($sformatf("u%0d_in_ready", u), ir[u], er);
        chk($sformatf("u%0d_drop_cnt", u), (u == 0) ? 64'(dca) : 64'(dcb), mcnt[u]);
        for (int k = 0; k < n; k++) begin
          chk($sformatf("u%0d_valid%0d", u, k), dut_v(u, k), mv[u][k]);
          if (mv[u][k]) begin
            chk($sformatf("u%0d_data%0d", u, k), dut_d(u, k), mdat[u][k]);
            chk($sformatf("u%0d_last%0d", u, k), dut_l(u, k), ml[u][k]);
          end
        end
      end
      if (u == 0) begin
        for (int k = 0; k < 4; k++)
          if (ova[k] && ordy[0][k]) drained.push_back('{k, int'(oda[k*8 +: 8]), int'(ola[k]), cyc});
        if (iv[0] && !ir[0] && !rst) stall_seen++;
      end else begin
        if (ovb != 3'b000) b_valid_seen++;
        if (!ir[1] && !rst) b_notready++;
      end
      if (rst) begin
        for (int k = 0; k < 4; k++) mv[u][k] = 1'b0;
        mcnt[u] = 0; mpkt[u] = 1'b0; mdest[u] = 0;
      end else begin
        for (int k = 0; k < n; k++) if (mv[u][k] && ordy[u][k]) mv[u][k] = 1'b0;
        if (iv[u] && er) begin
          if (d >= 0) begin
            mv[u][d] = 1'b1; mdat[u][d] = idat[u]; ml[u][d] = il[u];
          end else if (!mpkt[u] && mcnt[u] < cmax) begin
            mcnt[u]++;
          end
          mpkt[u]  = !il[u];
          mdest[u] = d;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) begin
      ordy[0] = 4'($urandom);
      ordy[1] = 4'($urandom);
    end else begin
      ordy[0] = (cyc >= stall_from && cyc < stall_from + 5) ? 4'b0111 : 4'b1111;
      ordy[1] = 4'b1111;
    end
  endtask

  task automatic send(input int u, input int sel, input int data, input bit last);
    bit acc;
    iv[u] = 1'b1; isel[u] = 2'(sel); idat[u] = 8'(data); il[u] = last;
    for (int i = 0; i < 200; i++) begin
      #2;
      acc = ir[u];
      tick();
      if (acc) begin
        iv[u] = 1'b0;
        return;
      end
    end
    chk($sformatf("u%0d_accept_timeout", u), 64'd0, 64'd1);
    iv[u] = 1'b0;
  endtask

  task automatic check_beat(input string nm, input int i, input int ch, input int data,
                            input int last, input bit consec);
    if (i < drained.size()) begin
      chk({nm, "_ch"}, drained[i].ch, ch);
      chk({nm, "_data"}, drained[i].data, data);
      chk({nm, "_last"}, drained[i].last, last);
      if (consec && i > 0) chk({nm, "_rate"}, drained[i].cyc - drained[i-1].cyc, 1);
    end
  endtask

  initial begin
    rst = 1'b1; iv = 2'b00; il = 2'b00;
    idat[0] = 8'h00; idat[1] = 8'h00; isel[0] = 2'd0; isel[1] = 2'd0;
    ordy[0] = 4'b1111; ordy[1] = 4'b1111;
    repeat (3) tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // three-beat packet to channel 2 at full rate
    drained.delete();
    send(0, 2, 8'h11, 1'b0); send(0, 2, 8'h22, 1'b0); send(0, 2, 8'h33, 1'b1);
    repeat (3) tick();
    chk("pkt3_count", drained.size(), 3);
    check_beat("pkt3_b0", 0, 2, 8'h11, 0, 1'b1);
    check_beat("pkt3_b1", 1, 2, 8'h22, 0, 1'b1);
    check_beat("pkt3_b2", 2, 2, 8'h33, 1, 1'b1);

    // in_sel changes mid-packet and must be ignored
    drained.delete();
    send(0, 1, 8'hA1, 1'b0); send(0, 0, 8'hA2, 1'b0); send(0, 0, 8'hA3, 1'b1);
    repeat (3) tick();
    chk("selchg_count", drained.size(), 3);
    for (int i = 0; i < 3; i++) check_beat("selchg", i, 1, 8'hA1 + i, (i == 2) ? 1 : 0, 1'b0);

    // channel 3 back-pressured for five cycles
    drained.delete(); stall_seen = 0; stall_from = cyc + 1;
    for (int i = 0; i < 4; i++) send(0, 3, 8'h31 + i, (i == 3));
    repeat (8) tick();
    chk("stall_ready_low", stall_seen > 0, 1);
    chk("stall_count", drained.size(), 4);
    for (int i = 0; i < 4; i++) check_beat("stall", i, 3, 8'h31 + i, (i == 3) ? 1 : 0, 1'b0);

    // bad destination on the 3-channel instance, then counter saturation
    b_valid_seen = 0; b_notready = 0;
    for (int i = 0; i < 4; i++) send(1, 3, 8'hB0 + i, (i == 3));
    repeat (2) tick();
    chk("drop_one", dcb, 2'd1);
    for (int p = 0; p < 5; p++) begin
      if (p[0]) send(1, 3, 8'hC0, 1'b0);
      send(1, 3, 8'hC1, 1'b1);
    end
    repeat (2) tick();
    chk("drop_sat", dcb, 2'd3);
    chk("drop_no_valid", b_valid_seen, 0);
    chk("drop_always_ready", b_notready, 0);

    // reset during beat 2 of a channel-0 packet
    send(0, 0, 8'h01, 1'b0);
    iv[0] = 1'b1; isel[0] = 2'd0; idat[0] = 8'h02; il[0] = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; iv[0] = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", ova, 4'b0000);
    tick();
    drained.delete();
    send(0, 1, 8'h77, 1'b1);
    repeat (2) tick();
    chk("rst_next_count", drained.size(), 1);
    check_beat("rst_next", 0, 1, 8'h77, 1, 1'b0);

    // back-to-back single-beat packets across channels
    drained.delete();
    for (int i = 0; i < 5; i++) send(0, i % 4, 8'h50 + i, 1'b1);
    repeat (3) tick();
    chk("b2b_count", drained.size(), 5);
    for (int i = 0; i < 5; i++) check_beat("b2b", i, i % 4, 8'h50 + i, 1, 1'b1);

    // randomized traffic and back-pressure on both instances
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) tick();
      else send($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 255),
                ($urandom_range(0, 2) == 0));
    end
    rand_rdy = 1'b0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_demux_1_n.md
STREAM_DEMUX_1_N -- requirements
Module: stream_demux_1_n

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of output channels (2..16).
REQ-002 SHALL have parameter DW, default 8, data width in bits (1..64).
REQ-003 SHALL have parameter CNT_W, default 16, drop-counter width.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  input beat present.
REQ-007 SHALL have port in_ready  output  1  input beat accepted when in_valid && in_ready.
REQ-008 SHALL have port in_data  input  DW  input payload.
REQ-009 SHALL have port in_sel  input  clog2(N_CH)  destination channel; sampled only on a packet's first beat.
REQ-010 SHALL have port in_last  input  1  final beat of packet.
REQ-011 SHALL have port out_valid  output  N_CH  per-channel beat present.
REQ-012 SHALL have port out_ready  input  N_CH  per-channel sink ready.
REQ-013 SHALL have port out_data  output  N_CH*DW  channel k at bits [k*DW +: DW].
REQ-014 SHALL have port out_last  output  N_CH  per-channel last flag.
REQ-015 SHALL have port drop_cnt  output  CNT_W  count of dropped packets, saturating.

Function
REQ-016 SHALL implement FSM states IDLE (awaiting first beat), FWD (forwarding to locked channel), DROP (discarding packet).
REQ-017 SHALL, in IDLE, on an accepted beat with in_sel < N_CH, lock tgt = in_sel; go to FWD if !in_last, else stay in IDLE.
REQ-018 SHALL, in IDLE, on an accepted beat with in_sel >= N_CH (non-power-of-2 N_CH only), discard the beat; go to DROP if !in_last, else stay in IDLE; increment drop_cnt once per packet.
REQ-019 SHALL, in FWD, ignore in_sel and route every accepted beat to tgt; return to IDLE on an accepted in_last beat.
REQ-020 SHALL, in DROP, hold in_ready = 1, discard beats, and return to IDLE on an accepted in_last beat.
REQ-021 SHALL drive in_ready = !out_valid[c] || out_ready[c], c = in_sel in IDLE or tgt in FWD; no combinational path from in_valid to in_ready.
REQ-022 SHALL register each beat into a one-entry output slot; out_valid[c] rises the cycle after acceptance (latency 1).
REQ-023 SHALL clear out_valid[k] after out_valid[k] && out_ready[k] unless a new beat loads the same cycle; load and drain in one cycle sustain 1 beat/cycle.
REQ-024 SHALL hold out_data/out_last of a channel stable while out_valid && !out_ready.
REQ-025 SHALL keep non-target channels unchanged; stalls on one channel never alter another channel's slot.
REQ-026 SHALL saturate drop_cnt at 2^CNT_W-1; no wrap.
REQ-027 SHALL treat a single beat with in_last = 1 as a complete one-beat packet.

Reset
REQ-028 SHALL, while rst = 1 at a clock edge, set state = IDLE, tgt = 0, out_valid = 0, out_data = 0, out_last = 0, drop_cnt = 0.
REQ-029 SHALL drive in_ready = 0 during any cycle with rst = 1.
REQ-030 SHALL discard any partly forwarded packet and buffered beats on reset mid-packet; the next accepted beat is a first beat.

Structure
REQ-031 SHALL place the state enum (IDLE/FWD/DROP) and the SEL_W = clog2(N_CH) function in shared package stream_demux_pkg.
REQ-032 SHALL instantiate sub-module demux_out_slot (one-entry valid/ready register, DW+1 bits) once per channel via generate.

Verification
REQ-033 SHALL cover: N_CH=4, DW=8, all out_ready=1, 3-beat packet sel=2 data 0x11,0x22,0x33 -> out_valid[2] on cycles +1..+3, same data, out_last on 0x33; channels 0,1,3 idle.
REQ-034 SHALL cover: sel changes to 0 on beats 2-3 of a sel=1 packet -> all beats on channel 1.
REQ-035 SHALL cover: out_ready[3]=0 for 5 cycles during a sel=3 packet -> in_ready=0 after slot fills, out_data held, no beat lost or duplicated after release.
REQ-036 SHALL cover: N_CH=3, packet sel=3 of 4 beats -> no out_valid, in_ready=1 throughout, drop_cnt 0->1; CNT_W=2 with 5 bad packets -> drop_cnt stays 3.
REQ-037 SHALL cover: rst=1 during beat 2 of a sel=0 packet -> next cycle out_valid=0, state IDLE; next beat with sel=1 routes to channel 1.
REQ-038 SHALL cover: back-to-back one-beat packets sel 0,1,2,3,0 with all ready -> 1 beat/cycle, each on its channel with out_last=1.
